// File: rtl/fp_addsub_norm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point adder datapath stages.
//   - fp_op_e       : significand operation encoding (add / subtract)
//   - SP_* / DP_*   : fraction / exponent widths for single and double formats
//   - exp_all_ones  : all-ones biased exponent for a given exponent width
// ---------------------------------------------------------------------------
package fp_pkg;

    typedef enum logic {
        FP_OP_ADD = 1'b0,
        FP_OP_SUB = 1'b1
    } fp_op_e;

    localparam int SP_FRAC_W = 23;
    localparam int SP_EXP_W  = 8;
    localparam int DP_FRAC_W = 52;
    localparam int DP_EXP_W  = 11;

    // Reserved (infinity / NaN) exponent code for an exp_w-bit field.
    function automatic logic [31:0] exp_all_ones(input int exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_addsub_norm_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_norm_pipe_if
// Operand / result bundle of the significand add-subtract-normalise stage.
//   Upstream side : i_valid, o_ready, i_op, i_large_exp, i_large_frac,
//                   i_small_frac (significands are {hidden, frac, G, S})
//   Downstream    : o_valid, i_ready, o_exp, o_frac, o_zero, o_oflow, o_uflow
// Modports:
//   master : the environment driving operands and consuming results
//   slave  : the pipeline stage itself
// ---------------------------------------------------------------------------
interface fp_addsub_norm_pipe_if #(
    parameter int FRAC_W = fp_pkg::SP_FRAC_W,
    parameter int EXP_W  = fp_pkg::SP_EXP_W
);
    logic                i_valid;
    logic                o_ready;
    logic                i_op;
    logic [EXP_W-1:0]    i_large_exp;
    logic [FRAC_W+2:0]   i_large_frac;
    logic [FRAC_W+2:0]   i_small_frac;
    logic                o_valid;
    logic                i_ready;
    logic [EXP_W-1:0]    o_exp;
    logic [FRAC_W-1:0]   o_frac;
    logic                o_zero;
    logic                o_oflow;
    logic                o_uflow;

    modport master (
        output i_valid, i_op, i_large_exp, i_large_frac, i_small_frac, i_ready,
        input  o_ready, o_valid, o_exp, o_frac, o_zero, o_oflow, o_uflow
    );

    modport slave (
        input  i_valid, i_op, i_large_exp, i_large_frac, i_small_frac, i_ready,
        output o_ready, o_valid, o_exp, o_frac, o_zero, o_oflow, o_uflow
    );
endinterface

// File: rtl/fp_addsub_norm_pipe_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter built as a binary tree.
//   i_data : W-bit vector, MSB first
//   o_cnt  : number of leading zeros (W when i_data is all zero)
//   o_zero : i_data is all zero
// The input is padded on the right with ones up to a power of two so the
// padding never adds to the count.
// ---------------------------------------------------------------------------
module fp_lzc #(
    parameter int W = 26
) (
    input  logic [W-1:0]             i_data,
    output logic [$clog2(W+1)-1:0]   o_cnt,
    output logic                     o_zero
);
    localparam int L  = (W < 2) ? 1 : $clog2(W);
    localparam int P  = 1 << L;
    localparam int CW = $clog2(W+1);

    logic [P-1:0] padded;

    generate
        if (P > W) begin : g_pad
            assign padded = {i_data, {(P-W){1'b1}}};
        end else begin : g_nopad
            assign padded = i_data;
        end
    endgenerate

    // Level k holds P>>k nodes; each node covers 2^k bits and reports
    // whether its span is all zero and the leading-zero count inside it.
    genvar k, j;
    generate
        for (k = 0; k <= L; k++) begin : lvl
            localparam int N = P >> k;
            logic [N-1:0] zero;
            logic [L-1:0] cnt [N];
            for (j = 0; j < N; j++) begin : node
                if (k == 0) begin : g_leaf
                    assign zero[j] = ~padded[P-1-j];
                    assign cnt[j]  = '0;
                end else begin : g_merge
                    // Right count is below 2^(k-1), so OR acts as an add.
                    assign zero[j] = lvl[k-1].zero[2*j] & lvl[k-1].zero[2*j+1];
                    assign cnt[j]  = lvl[k-1].zero[2*j]
                                   ? (L'(1 << (k-1)) | lvl[k-1].cnt[2*j+1])
                                   : lvl[k-1].cnt[2*j];
                end
            end
        end
    endgenerate

    assign o_zero = ~|i_data;
    assign o_cnt  = lvl[L].zero[0] ? CW'(W) : CW'(lvl[L].cnt[0]);

endmodule

// File: rtl/fp_addsub_norm_pipe.sv
// ---------------------------------------------------------------------------
// fp_addsub_norm_pipe
// Pipelined significand add/subtract and normalise stage of the FP adder,
// between exponent align and result packing. Three register stages, each
// with its own valid bit and full valid/ready backpressure.
//   i_clk, i_rst : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : operands in (i_valid/o_ready handshake), result out
//                  (o_valid/i_ready handshake) with zero/overflow/underflow
// Parameters: FRAC_W stored fraction bits, EXP_W biased exponent bits.
// Build option: FP_ADDSUB_RNE_EN selects round-to-nearest-even in S3;
// without it S3 truncates and is a plain register stage.
// ---------------------------------------------------------------------------
module fp_addsub_norm_pipe
    import fp_pkg::*;
#(
    parameter int FRAC_W = SP_FRAC_W,
    parameter int EXP_W  = SP_EXP_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    fp_addsub_norm_pipe_if.slave   bus
);
    localparam int M     = FRAC_W + 3;
    localparam int SUM_W = FRAC_W + 4;
    localparam int LZ_W  = $clog2(M + 1);
    localparam int XW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(exp_all_ones(EXP_W));

    logic s1_valid, s2_valid, s3_valid;
    logic s1_adv, s2_adv, s3_adv;

    // A stage moves when it is empty or the stage after it moves.
    assign s3_adv      = !s3_valid | bus.i_ready;
    assign s2_adv      = !s2_valid | s3_adv;
    assign s1_adv      = !s1_valid | s2_adv;
    assign bus.o_ready = s1_adv;

    // ------------------------------------------------------------- S1 add
    logic [SUM_W-1:0] small_ext, s1_sum_d, s1_sum;
    logic [EXP_W-1:0] s1_exp;

    assign small_ext = {1'b0, bus.i_small_frac};
    assign s1_sum_d  = {1'b0, bus.i_large_frac}
                     + ((bus.i_op == FP_OP_SUB) ? -small_ext : small_ext);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_exp   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_sum <= s1_sum_d;
                s1_exp <= bus.i_large_exp;
            end
        end
    end

    // ------------------------------------------------------ S2 normalise
    logic [M-1:0]       low;
    logic [LZ_W-1:0]    lzc;
    logic               lzc_zero;
    logic [EXP_W-1:0]   exp_eff;
    logic [EXP_W:0]     exp_inc;
    logic [XW-1:0]      lzc_x, exp_x, shamt;
    logic [M-1:0]       n_sig;
    logic [EXP_W-1:0]   n_exp;
    logic               n_zero, n_oflow, n_uflow;

    assign low     = s1_sum[M-1:0];
    // A denormal operand (exponent 0) has the same scale as exponent 1.
    assign exp_eff = (s1_exp == '0) ? EXP_W'(1) : s1_exp;

    fp_lzc #(.W(M)) u_lzc (
        .i_data (low),
        .o_cnt  (lzc),
        .o_zero (lzc_zero)
    );

    // Carry renormalises right; otherwise shift left but never push the
    // exponent below 1, leaving a denormal flagged as underflow.
    always_comb begin
        n_sig   = '0;
        n_exp   = '0;
        n_zero  = 1'b0;
        n_oflow = 1'b0;
        n_uflow = 1'b0;
        exp_inc = {1'b0, exp_eff} + (EXP_W+1)'(1);
        lzc_x   = XW'(lzc);
        exp_x   = XW'(exp_eff);
        shamt   = '0;
        if (s1_sum[SUM_W-1]) begin
            if (exp_inc >= {1'b0, EXP_MAX}) begin
                n_oflow = 1'b1;
                n_exp   = EXP_MAX;
            end else begin
                n_exp = exp_inc[EXP_W-1:0];
                n_sig = {s1_sum[SUM_W-1:2], |s1_sum[1:0]};
            end
        end else if (lzc_zero) begin
            n_zero = 1'b1;
        end else if (lzc_x >= exp_x) begin
            n_uflow = 1'b1;
            shamt   = exp_x - XW'(1);
            n_sig   = low << shamt;
        end else begin
            shamt = lzc_x;
            n_exp = EXP_W'(exp_x - lzc_x);
            n_sig = low << shamt;
        end
    end

    logic [EXP_W-1:0] s2_exp;
    logic             s2_zero, s2_oflow, s2_uflow;
`ifdef FP_ADDSUB_RNE_EN
    logic [M-1:0]      s2_sig;
`else
    logic [FRAC_W-1:0] s2_frac;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_exp   <= '0;
            s2_zero  <= 1'b0;
            s2_oflow <= 1'b0;
            s2_uflow <= 1'b0;
`ifdef FP_ADDSUB_RNE_EN
            s2_sig   <= '0;
`else
            s2_frac  <= '0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_exp   <= n_exp;
                s2_zero  <= n_zero;
                s2_oflow <= n_oflow;
                s2_uflow <= n_uflow;
`ifdef FP_ADDSUB_RNE_EN
                s2_sig   <= n_sig;
`else
                // Only the stored fraction survives truncation.
                s2_frac  <= FRAC_W'(n_sig >> 2);
`endif
            end
        end
    end

    // ---------------------------------------------------------- S3 round
    logic [EXP_W-1:0]  r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic              r_oflow;

`ifdef FP_ADDSUB_RNE_EN
    logic              rnd_inc;
    logic [FRAC_W+1:0] rnd;
    logic [EXP_W:0]    exp_bump;

    assign rnd_inc  = s2_sig[1] & (s2_sig[0] | s2_sig[2]);
    assign rnd      = {1'b0, s2_sig[M-1:2]} + (FRAC_W+2)'(rnd_inc);
    assign exp_bump = {1'b0, s2_exp} + (EXP_W+1)'(1);

    always_comb begin
        r_exp   = s2_exp;
        r_frac  = rnd[FRAC_W-1:0];
        r_oflow = s2_oflow;
        if (rnd[FRAC_W+1]) begin
            if (exp_bump >= {1'b0, EXP_MAX}) begin
                r_oflow = 1'b1;
                r_exp   = EXP_MAX;
                r_frac  = '0;
            end else begin
                r_exp  = exp_bump[EXP_W-1:0];
                r_frac = rnd[FRAC_W:1];
            end
        end else if (s2_exp == '0 && rnd[FRAC_W]) begin
            // A denormal that rounds up into the hidden bit becomes normal.
            r_exp = EXP_W'(1);
        end
    end
`else
    assign r_exp   = s2_exp;
    assign r_frac  = s2_frac;
    assign r_oflow = s2_oflow;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s3_valid    <= 1'b0;
            bus.o_exp   <= '0;
            bus.o_frac  <= '0;
            bus.o_zero  <= 1'b0;
            bus.o_oflow <= 1'b0;
            bus.o_uflow <= 1'b0;
        end else if (s3_adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                bus.o_exp   <= r_exp;
                bus.o_frac  <= r_frac;
                bus.o_zero  <= s2_zero;
                bus.o_oflow <= r_oflow;
                bus.o_uflow <= s2_uflow;
            end
        end
    end

    assign bus.o_valid = s3_valid;

    // The datapath assumes the aligned small significand never exceeds the
    // large one; anything else produces a meaningless result.
    small_le_large_a : assert property (
        @(posedge i_clk) disable iff (i_rst)
        (bus.i_valid && bus.o_ready) |-> (bus.i_small_frac <= bus.i_large_frac)
    );

endmodule
